fetch: RTL and testbench



---
 rtl/lc3b_types.sv | 18 +
 rtl/if_id_reg.sv | 31 +++
 rtl/register.sv | 21 ++
 rtl/fetch.sv | 153 +++++++++++++++
 tb/tb_fetch.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: machine word, fetch-stage FSM states and a PC helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    SQUASH
  } fetch_state_t;

  // Instructions are word-aligned; the increment wraps at the top of memory.
  function automatic lc3b_word pc_inc(input lc3b_word pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction or records a bubble.
module if_id_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load,
  input  logic     bubble,
  input  lc3b_word npc_in,
  input  lc3b_word ir_in,
  output lc3b_word npc,
  output lc3b_word ir,
  output logic     valid
);

  // A bubble only clears valid; npc/ir keep their stale contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      npc   <= 16'h0000;
      ir    <= 16'h0000;
      valid <= 1'b0;
    end else if (load) begin
      npc   <= npc_in;
      ir    <= ir_in;
      valid <= 1'b1;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/register.sv
// Generic loadable register with asynchronous active-low reset to a fixed value.
module register #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VAL;
    end else if (load) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/fetch.sv
// LC-3b fetch stage: PC, instruction-memory handshake, decode back-pressure buffer and
// branch redirect with squash of an in-flight request.
module fetch
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_in,
  input  logic        fetch_hold,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] npc,
  output logic [15:0] ir,
  output logic        valid
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  lc3b_word     r_imem_address;
  lc3b_word     r_buf;

  lc3b_word w_pc;
  lc3b_word w_pc_inc;
  lc3b_word w_pc_next;
  logic     w_pc_load;
  logic     w_pc_sel_br;
  logic     w_addr_load;
  lc3b_word w_addr_next;
  logic     w_buf_load;
  logic     w_id_load;
  lc3b_word w_id_ir;
  logic     w_id_bubble;

  assign w_pc_inc  = pc_inc(w_pc);
  assign w_pc_next = w_pc_sel_br ? {br_target[15:1], 1'b0} : w_pc_inc;

  register #(
    .WIDTH     (16),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_pc_load),
    .data_in  (w_pc_next),
    .data_out (w_pc)
  );

  // br_taken is checked first in every state so it overrides stall, hold and resp.
  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_pc_sel_br  = 1'b0;
    w_addr_load  = 1'b0;
    w_addr_next  = w_pc_inc;
    w_buf_load   = 1'b0;
    w_id_load    = 1'b0;
    w_id_ir      = imem_rdata;
    unique case (r_state)
      IDLE: begin
        w_addr_next = w_pc;
        if (br_taken) begin
          w_pc_load   = 1'b1;
          w_pc_sel_br = 1'b1;
        end else if (!fetch_hold) begin
          w_addr_load  = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (br_taken) begin
          w_pc_load    = 1'b1;
          w_pc_sel_br  = 1'b1;
          w_state_next = imem_resp ? IDLE : SQUASH;
        end else if (imem_resp) begin
          if (!stall_in) begin
            w_id_load = 1'b1;
            w_pc_load = 1'b1;
            if (!fetch_hold) begin
              w_addr_load = 1'b1;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_buf_load   = 1'b1;
            w_state_next = HOLD;
          end
        end
      end
      HOLD: begin
        w_id_ir = r_buf;
        if (br_taken) begin
          w_pc_load    = 1'b1;
          w_pc_sel_br  = 1'b1;
          w_state_next = IDLE;
        end else if (!stall_in) begin
          w_id_load    = 1'b1;
          w_pc_load    = 1'b1;
          w_state_next = IDLE;
        end
      end
      SQUASH: begin
        if (br_taken) begin
          w_pc_load   = 1'b1;
          w_pc_sel_br = 1'b1;
        end
        if (imem_resp) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_id_bubble = !stall_in && !w_id_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_imem_address <= RESET_PC;
      r_buf          <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (w_addr_load) begin
        r_imem_address <= w_addr_next;
      end
      if (w_buf_load) begin
        r_buf <= imem_rdata;
      end
    end
  end

  assign imem_address = r_imem_address;
  assign imem_read    = (r_state == REQ) || (r_state == SQUASH);

  if_id_reg u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (w_id_load),
    .bubble  (w_id_bubble),
    .npc_in  (w_pc_inc),
    .ir_in   (w_id_ir),
    .npc     (npc),
    .ir      (ir),
    .valid   (valid)
  );

endmodule

// File: tb/tb_fetch.sv
// Randomized bench for the fetch stage against a transaction-level model of the stage.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] imem_address;
  logic        imem_read;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        stall_in;
  logic        fetch_hold;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] npc;
  logic [15:0] ir;
  logic        valid;

  always #5 clk = ~clk;

  fetch #(
    .RESET_PC (16'h0000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall_in     (stall_in),
    .fetch_hold   (fetch_hold),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .npc          (npc),
    .ir           (ir),
    .valid        (valid)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Model: pc, outstanding request (possibly doomed), one buffered word, IF/ID contents.
  logic [15:0] m_pc, m_addr, m_buf, m_npc, m_ir;
  bit          m_busy, m_squash, m_have_buf, m_valid;
  int unsigned m_wait;
  int unsigned max_lat;

  task automatic model_reset();
    m_pc = 16'h0000; m_addr = 16'h0000; m_buf = 16'h0000;
    m_npc = 16'h0000; m_ir = 16'h0000; m_valid = 1'b0;
    m_busy = 1'b0; m_squash = 1'b0; m_have_buf = 1'b0; m_wait = 0;
  endtask

  task automatic start_req();
    m_busy   = 1'b1;
    m_squash = 1'b0;
    m_wait   = $urandom_range(0, max_lat);
  endtask

  task automatic model_step(input bit s, input bit h, input bit b, input logic [15:0] t,
                            input bit r, input logic [15:0] d);
    bit          ld;
    logic [15:0] ld_ir, ld_npc, tg;
    ld = 1'b0; ld_ir = 16'h0; ld_npc = 16'h0;
    tg = {t[15:1], 1'b0};
    if (m_have_buf) begin
      if (b) begin
        m_have_buf = 1'b0; m_pc = tg;
      end else if (!s) begin
        ld = 1'b1; ld_ir = m_buf; ld_npc = m_pc + 16'd2;
        m_pc = m_pc + 16'd2; m_have_buf = 1'b0;
      end
    end else if (!m_busy) begin
      if (b) m_pc = tg;
      else if (!h) begin
        m_addr = m_pc; start_req();
      end
    end else if (m_squash) begin
      if (b) m_pc = tg;
      if (r) begin
        m_busy = 1'b0; m_squash = 1'b0;
      end
    end else begin
      if (b) begin
        m_pc = tg;
        if (r) m_busy = 1'b0;
        else m_squash = 1'b1;
      end else if (r) begin
        if (!s) begin
          ld = 1'b1; ld_ir = d; ld_npc = m_pc + 16'd2;
          m_pc = m_pc + 16'd2;
          if (!h) begin
            m_addr = m_pc; start_req();
          end else m_busy = 1'b0;
        end else begin
          m_buf = d; m_have_buf = 1'b1; m_busy = 1'b0;
        end
      end
    end
    if (!s) begin
      if (ld) begin
        m_valid = 1'b1; m_ir = ld_ir; m_npc = ld_npc;
      end else m_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string where);
    check_eq({where, " imem_read"}, {15'b0, imem_read}, {15'b0, m_busy});
    check_eq({where, " imem_address"}, imem_address, m_addr);
    check_eq({where, " valid"}, {15'b0, valid}, {15'b0, m_valid});
    check_eq({where, " npc"}, npc, m_npc);
    check_eq({where, " ir"}, ir, m_ir);
  endtask

  task automatic drive_idle();
    stall_in = 1'b0; fetch_hold = 1'b0; br_taken = 1'b0;
    br_target = 16'h0000; imem_resp = 1'b0; imem_rdata = 16'h0000;
  endtask

  // Reset asserted between clock edges: outputs must clear without waiting for a clock.
  task automatic apply_reset();
    #1;
    reset_n = 1'b0;
    drive_idle();
    #1;
    model_reset();
    compare_all("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int unsigned stall_pct[4] = '{0, 30, 20, 25};
  int unsigned hold_pct[4]  = '{0, 0, 25, 20};
  int unsigned br_pct[4]    = '{0, 0, 5, 15};

  initial begin
    bit          s, h, b, r;
    logic [15:0] t, d;
    reset_n = 1'b0;
    drive_idle();
    max_lat = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int phase = 0; phase < 4; phase++) begin
      max_lat = (phase == 0) ? 0 : 3;
      for (int cyc = 0; cyc < 500; cyc++) begin
        compare_all($sformatf("p%0d", phase));
        if (cyc == 300) begin
          apply_reset();
          continue;
        end
        s = ($urandom_range(0, 99) < stall_pct[phase]);
        h = ($urandom_range(0, 99) < hold_pct[phase]);
        b = ($urandom_range(0, 99) < br_pct[phase]);
        case ($urandom_range(0, 3))
          0:       t = 16'h0040;
          1:       t = 16'hFFFE;
          2:       t = 16'hFFFD;
          default: t = 16'($urandom);
        endcase
        r = 1'b0;
        if (m_busy) begin
          if (m_wait == 0) r = 1'b1;
          else m_wait--;
        end
        d = r ? mem_word(m_addr) : 16'($urandom);
        stall_in = s; fetch_hold = h; br_taken = b; br_target = t;
        imem_resp = r; imem_rdata = d;
        @(posedge clk);
        model_step(s, h, b, t, r, d);
        @(negedge clk);
      end
    end
    compare_all("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
